modmul_iter: RTL and testbench

//  Iterative bit-serial modular multiplier C = A*B mod q, with q = {qH, {(LOGQ-LOGQH-1){1'b0}}, 1'b1}.

---
 rtl/modmul_iter.sv | 186 ++++++++++++++++++
 tb/tb_modmul_iter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/modmul_iter.sv
// -----------------------------------------------------------------------------
// modmul_iter
//   Iterative MSB-first interleaved modular multiplier, C = A*B mod q, where
//   q = {qH, zeros, 1'b1} (LOGQ bits). One multiplier bit is consumed per clock,
//   so a result is ready LOGQ cycles after the operands are accepted.
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   A/B/qH valid             in_ready   block can accept operands
//   A, B       operands (< q)           qH         modulus high part
//   out_valid  C valid until out_ready  out_ready  downstream accepts C
//   C          result in [0, q-1]       err        operand range error flag
//
// Optional feature: define MODMUL_ITER_RANGE_CHECK_EN to flag A >= q or B >= q
// at accept; the op then completes one cycle later with C = 0 and err = 1.
// Without the macro err is tied low and no check is made.
// -----------------------------------------------------------------------------
module modmul_iter #(
   parameter int unsigned LOGQ  = 64,
   parameter int unsigned LOGQH = 47
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [LOGQ-1:0]  A,
   input  logic [LOGQ-1:0]  B,
   input  logic [LOGQH-1:0] qH,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LOGQ-1:0]  C,
   output logic             err
);

   localparam int unsigned CNT_W = (LOGQ > 1) ? $clog2(LOGQ) : 1;
   localparam int unsigned QH_SH = LOGQ - LOGQH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // q = qH in the top bits, bit 0 set, zeros in between
   function automatic logic [LOGQ-1:0] build_q(input logic [LOGQH-1:0] qh);
      return (LOGQ'(qh) << QH_SH) | LOGQ'(1);
   endfunction

   // x - q if x >= q (x < 2q); the sign bit of the LOGQ+1 bit difference decides
   function automatic logic [LOGQ-1:0] mod_reduce(input logic [LOGQ:0]   x,
                                                  input logic [LOGQ-1:0] q);
      logic [LOGQ:0] diff;
      diff = x - {1'b0, q};
      return diff[LOGQ] ? x[LOGQ-1:0] : diff[LOGQ-1:0];
   endfunction

   state_e           state_q, state_d;
   logic [LOGQ-1:0]  a_q, a_d;
   logic [LOGQ-1:0]  b_q, b_d;
   logic [LOGQH-1:0] qh_q, qh_d;
   logic [LOGQ-1:0]  r_q, r_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [LOGQ-1:0]  c_q, c_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             err_q, err_d;

   logic [LOGQ-1:0]  q_run;
   logic [LOGQ-1:0]  dbl_c;
   logic [LOGQ-1:0]  sum_c;

   // One interleaved step: R <- (2R mod q + B[cnt]*A) mod q
   always_comb begin
      q_run = build_q(qh_q);
      dbl_c = mod_reduce({r_q, 1'b0}, q_run);
      sum_c = mod_reduce({1'b0, dbl_c} + (b_q[cnt_q] ? {1'b0, a_q} : {(LOGQ+1){1'b0}}),
                         q_run);
   end

`ifdef MODMUL_ITER_RANGE_CHECK_EN
   logic [LOGQ-1:0] q_in;
   logic            range_bad;

   always_comb begin
      q_in      = build_q(qH);
      range_bad = (A >= q_in) || (B >= q_in);
   end
`endif

   // Next-state and datapath control
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      qh_d        = qh_q;
      r_d         = r_q;
      cnt_d       = cnt_q;
      c_d         = c_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      err_d       = err_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d        = A;
               b_d        = B;
               qh_d       = qH;
               r_d        = '0;
               cnt_d      = CNT_W'(LOGQ - 1);
               in_ready_d = 1'b0;
               state_d    = RUN;
`ifdef MODMUL_ITER_RANGE_CHECK_EN
               // A bad op spends one RUN cycle only, then reports C = 0
               err_d      = range_bad;
`else
               err_d      = 1'b0;
`endif
            end
         end
         RUN: begin
            if (err_q) begin
               c_d         = '0;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               r_d   = sum_c;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == '0) begin
                  c_d         = sum_c;
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers, synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         qh_q        <= '0;
         r_q         <= '0;
         cnt_q       <= '0;
         c_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         qh_q        <= qh_d;
         r_q         <= r_d;
         cnt_q       <= cnt_d;
         c_q         <= c_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign C         = c_q;
`ifdef MODMUL_ITER_RANGE_CHECK_EN
   assign err       = err_q && (state_q == DONE);
`else
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_modmul_iter.sv
// -----------------------------------------------------------------------------
// tb_modmul_iter
//   Self-checking bench for modmul_iter: directed cases plus randomized operand
//   pairs with random output stalls, checked against (A*B) % q.
// -----------------------------------------------------------------------------
module tb_modmul_iter;

   localparam int unsigned LOGQ  = 64;
   localparam int unsigned LOGQH = 47;
   localparam logic [LOGQH-1:0] QH = 47'h400008C00000;
   localparam logic [LOGQ-1:0]  Q  = 64'h8000118000000001;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [LOGQ-1:0] a_in;
   logic [LOGQ-1:0] b_in;
   logic            out_valid;
   logic            out_ready;
   logic [LOGQ-1:0] c_out;
   logic            err;

   int checks   = 0;
   int failures = 0;

   modmul_iter #(.LOGQ(LOGQ), .LOGQH(LOGQH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (a_in),
      .B         (b_in),
      .qH        (QH),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .C         (c_out),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: full-width product reduced with the % operator
   function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
      logic [127:0] p;
      p = {64'd0, a} * {64'd0, b};
      return 64'(p % {64'd0, Q});
   endfunction

   function automatic logic [63:0] rand_op();
      logic [63:0] x;
      x = {$urandom, $urandom};
      return x % Q;
   endfunction

   // Issue one op, measure latency, apply 'stall' cycles of backpressure, retire it
   task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_c, input logic exp_err,
                         input int exp_lat, input int stall);
      int   lat;
      logic rdy_bad;
      logic hold_bad;
      @(negedge clk);
      check_eq({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
      a_in      = a;
      b_in      = b;
      in_valid  = 1'b1;
      out_ready = (stall == 0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat     = 0;
      rdy_bad = 1'b0;
      forever begin
         @(negedge clk);
         if (out_valid || lat >= 200) break;
         if (in_ready) rdy_bad = 1'b1;
         @(posedge clk);
         lat++;
      end
      check_eq({tag, ".latency"}, 64'(lat), 64'(exp_lat));
      check_eq({tag, ".in_ready_busy"}, 64'(rdy_bad), 64'd0);
      check_eq({tag, ".C"}, c_out, exp_c);
      check_eq({tag, ".err"}, 64'(err), 64'(exp_err));
      hold_bad = 1'b0;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (!out_valid || c_out !== exp_c || in_ready) hold_bad = 1'b1;
      end
      if (stall > 0) check_eq({tag, ".hold"}, 64'(hold_bad), 64'd0);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq({tag, ".out_valid_drop"}, 64'(out_valid), 64'd0);
      check_eq({tag, ".in_ready_back"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic        stale;
      logic        bp_bad;
      logic [63:0] ra, rb;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a_in      = '0;
      b_in      = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("reset.in_ready", 64'(in_ready), 64'd1);
      check_eq("reset.out_valid", 64'(out_valid), 64'd0);
      check_eq("reset.C", c_out, 64'd0);
      check_eq("reset.err", 64'(err), 64'd0);
      rst_n = 1'b1;

      // Directed values
      run_op("d_3x5", 64'd3, 64'd5, 64'd15, 1'b0, 64, 0);
      run_op("d_qm1sq", Q - 64'd1, Q - 64'd1, 64'd1, 1'b0, 64, 0);
      run_op("d_1xqm1", 64'd1, Q - 64'd1, 64'h8000118000000000, 1'b0, 64, 0);
      run_op("d_b0", 64'h123, 64'd0, 64'd0, 1'b0, 64, 0);
      run_op("d_a0", 64'd0, Q - 64'd1, 64'd0, 1'b0, 64, 1);

      // Backpressure: operands offered while DONE must be ignored
      @(negedge clk);
      a_in = 64'd3; b_in = 64'd5; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int i = 0; i < 200 && !out_valid; i++) @(negedge clk);
      check_eq("bp.valid", 64'(out_valid), 64'd1);
      bp_bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         a_in = 64'd7; b_in = 64'd9; in_valid = (i % 2) == 0;
         @(posedge clk);
         @(negedge clk);
         if (!out_valid || c_out !== 64'd15 || in_ready) bp_bad = 1'b1;
      end
      in_valid = 1'b0;
      check_eq("bp.hold", 64'(bp_bad), 64'd0);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("bp.release", 64'(out_valid), 64'd0);
      run_op("bp_7x9", 64'd7, 64'd9, 64'd63, 1'b0, 64, 0);

      // Reset in the middle of a run
      @(negedge clk);
      a_in = 64'd11; b_in = 64'd13; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_eq("rst_mid.out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_mid.C", c_out, 64'd0);
      check_eq("rst_mid.in_ready", 64'(in_ready), 64'd1);
      rst_n = 1'b1;
      stale = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (out_valid) stale = 1'b1;
      end
      check_eq("rst_mid.no_stale", 64'(stale), 64'd0);
      run_op("rst_2x2p62", 64'd2, 64'h4000000000000000,
             ref_mul(64'd2, 64'h4000000000000000), 1'b0, 64, 0);

`ifdef MODMUL_ITER_RANGE_CHECK_EN
      run_op("rng_aq", Q, 64'd1, 64'd0, 1'b1, 1, 0);
      run_op("rng_bq", 64'd1, Q + 64'd5, 64'd0, 1'b1, 1, 2);
      run_op("rng_ok", 64'd4, 64'd6, 64'd24, 1'b0, 64, 0);
`endif

      // Randomized pairs with random output stalls
      for (int n = 0; n < 600; n++) begin
         ra = rand_op();
         rb = rand_op();
         run_op("rand", ra, rb, ref_mul(ra, rb), 1'b0, 64, int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
